// File: rtl/fifo_rd_packer_if.sv
// Handshake bundle between a FWFT FIFO read port, the byte packer and its
// downstream word consumer.
interface fifo_rd_packer_if #(
    parameter int DSIZE = 8,
    parameter int LANES = 4,
    parameter int CSIZE = 3
);
    logic [DSIZE-1:0]       rdata;
    logic                   rempty;
    logic                   rinc;
    logic                   flush;
    logic [LANES*DSIZE-1:0] out_data;
    logic [CSIZE-1:0]       out_bytes;
    logic                   out_valid;
    logic                   out_ready;

    // The packer drives the pop strobe and the packed word.
    modport master (
        input  rdata, rempty, flush, out_ready,
        output rinc, out_data, out_bytes, out_valid
    );

    // The environment supplies FIFO data, flush and downstream ready.
    modport slave (
        output rdata, rempty, flush, out_ready,
        input  rinc, out_data, out_bytes, out_valid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Packs bytes from a first-word-fall-through FIFO into LANES-wide words,
// with flush of partial words and pop-during-handshake for full throughput.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int LANES = 4,
    parameter int CSIZE = 3
) (
    input  logic             rclk,
    input  logic             rrst_n,
    fifo_rd_packer_if.master bus
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_OUT  = 1'b1
    } state_e;

    typedef logic [LANES-1:0][DSIZE-1:0] word_t;

    state_e           state_q, state_d;
    logic [CSIZE-1:0] cnt_q, cnt_d;
    word_t            data_q, data_d;
    logic [CSIZE-1:0] bytes_q, bytes_d;
    logic             valid_q, valid_d;

    logic pop;
    logic last_lane;
    logic flush_take;

    assign last_lane  = (cnt_q == CSIZE'(LANES - 1));
    assign flush_take = (state_q == ST_FILL) && bus.flush && (cnt_q != '0);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge rclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rrst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path through the case leaves it unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            ST_FILL: begin
                if ((pop && last_lane) || flush_take) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic: the pop strobe is the only combinational output
    // ---------------------------------------------------------------------
    always_comb begin
        pop = 1'b0;
        if (rrst_n && !bus.rempty) begin
            unique case (state_q)
                ST_FILL: pop = !flush_take;
                ST_OUT:  pop = bus.out_ready;
                default: pop = 1'b0;
            endcase
        end
    end

    assign bus.rinc = pop;

    // ---------------------------------------------------------------------
    // Datapath next-state: lane writes, lane counter, presented word info
    // ---------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        data_d  = data_q;
        bytes_d = bytes_q;
        valid_d = valid_q;

        // cnt_q is 0 throughout OUT, so a handshake pop lands in lane 0 and
        // wipes the previous word's upper lanes in the same edge.
        if (pop) begin
            for (int i = 0; i < LANES; i++) begin
                if (cnt_q == CSIZE'(i)) begin
                    data_d[i] = bus.rdata;
                end else if (cnt_q == '0) begin
                    data_d[i] = '0;
                end
            end
        end

        unique case (state_q)
            ST_FILL: begin
                if (pop) begin
                    if (last_lane) begin
                        cnt_d   = '0;
                        bytes_d = CSIZE'(LANES);
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CSIZE'(1);
                    end
                end else if (flush_take) begin
                    cnt_d   = '0;
                    bytes_d = cnt_q;
                    valid_d = 1'b1;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = pop ? CSIZE'(1) : '0;
                end
            end
            default: begin
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        // NOTE: the lane storage is reset too, because a freshly reset block
        // must present an all-zero word rather than stale bytes.
        if (!rrst_n) begin
            cnt_q   <= '0;
            data_q  <= '0;
            bytes_q <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            bytes_q <= bytes_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_bytes = bytes_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed and randomized bench for fifo_rd_packer against a queue-based
// model of words being collected, presented and handed off.
module tb_fifo_rd_packer;

    localparam int DSIZE = 8;
    localparam int LANES = 4;
    localparam int CSIZE = 3;

    logic rclk;
    logic rrst_n;
    logic stall;

    int total = 0;
    int bad   = 0;

    fifo_rd_packer_if #(.DSIZE(DSIZE), .LANES(LANES), .CSIZE(CSIZE)) bus ();

    fifo_rd_packer #(.DSIZE(DSIZE), .LANES(LANES), .CSIZE(CSIZE)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus.master)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // FIFO contents, the word being gathered, and the word on display.
    logic [DSIZE-1:0] src[$];
    logic [DSIZE-1:0] acc[$];
    logic [DSIZE-1:0] shown[$];
    bit               presenting;
    int               popped_n;
    int               delivered_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*DSIZE-1:0] shown_word();
        logic [LANES*DSIZE-1:0] w;
        w = '0;
        for (int i = 0; i < shown.size(); i++) begin
            w[i*DSIZE +: DSIZE] = shown[i];
        end
        return w;
    endfunction

    // One clock: drive FIFO head, compare against the model, advance both.
    task automatic cycle();
        logic exp_rinc;
        logic [DSIZE-1:0] head;
        bus.rempty = (src.size() == 0) || stall;
        bus.rdata  = (src.size() != 0) ? src[0] : 8'hA5;
        head       = bus.rdata;
        #1;
        if (presenting) exp_rinc = !bus.rempty && bus.out_ready;
        else            exp_rinc = !bus.rempty && !(bus.flush && acc.size() != 0);

        check("rinc", bus.rinc, exp_rinc);
        check("out_valid", bus.out_valid, presenting);
        if (presenting) begin
            check("out_bytes", bus.out_bytes, shown.size());
            check("out_data", bus.out_data, shown_word());
        end

        if (presenting) begin
            if (bus.out_ready) begin
                presenting  = 1'b0;
                delivered_n += shown.size();
                if (exp_rinc) begin
                    acc.delete();
                    acc.push_back(head);
                end
            end
        end else if (exp_rinc) begin
            acc.push_back(head);
            if (acc.size() == LANES) begin
                shown = acc;
                acc.delete();
                presenting = 1'b1;
            end
        end else if (bus.flush && acc.size() != 0) begin
            shown = acc;
            acc.delete();
            presenting = 1'b1;
        end
        if (exp_rinc) popped_n++;

        @(posedge rclk);
        if (exp_rinc) void'(src.pop_front());
        #1;
    endtask

    task automatic apply_reset();
        rrst_n     = 1'b0;
        bus.rempty = (src.size() == 0);
        bus.rdata  = (src.size() != 0) ? src[0] : 8'hA5;
        #1;
        check("rinc_in_reset", bus.rinc, 1'b0);
        @(posedge rclk);
        #1;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_bytes", bus.out_bytes, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_rinc", bus.rinc, 1'b0);
        acc.delete();
        shown.delete();
        presenting = 1'b0;
        rrst_n = 1'b1;
    endtask

    initial begin
        logic [LANES*DSIZE-1:0] held;
        int guard;

        rrst_n        = 1'b0;
        stall         = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.rempty    = 1'b1;
        bus.rdata     = '0;
        presenting    = 1'b0;
        popped_n      = 0;
        delivered_n   = 0;

        apply_reset();

        // Single word at full rate.
        bus.out_ready = 1'b1;
        src = '{8'h11, 8'h22, 8'h33, 8'h44};
        repeat (4) cycle();
        check("s1_data", bus.out_data, 32'h44332211);
        check("s1_bytes", bus.out_bytes, 4);
        check("s1_valid", bus.out_valid, 1'b1);
        cycle();
        check("s1_valid_drop", bus.out_valid, 1'b0);

        // Two back-to-back words, rinc held high throughout.
        src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        repeat (4) cycle();
        check("s2_word0", bus.out_data, 32'h04030201);
        repeat (4) cycle();
        check("s2_word1", bus.out_data, 32'h08070605);
        cycle();

        // Partial word flushed out; flush with nothing gathered is ignored.
        src = '{8'hAA, 8'hBB, 8'hCC};
        repeat (3) cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        check("s3_data", bus.out_data, 32'h00CCBBAA);
        check("s3_bytes", bus.out_bytes, 3);
        cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        check("s3_empty_flush", bus.out_valid, 1'b0);

        // Backpressure holds the word; release pops straight into lane 0.
        bus.out_ready = 1'b0;
        src = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        repeat (4) cycle();
        held = bus.out_data;
        repeat (5) cycle();
        check("s4_hold", bus.out_data, held);
        bus.out_ready = 1'b1;
        cycle();
        check("s4_lane0_pop", bus.out_data, 32'h00000014);
        repeat (3) cycle();
        check("s4_word1", bus.out_data, 32'h17161514);
        cycle();

        // Reset mid-word drops the partial bytes; next word is clean.
        src = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
        repeat (2) cycle();
        apply_reset();
        repeat (4) cycle();
        check("s5_clean", bus.out_data, 32'h25242322);
        check("s5_bytes", bus.out_bytes, 4);
        src.delete();
        cycle();

        // Randomized traffic against the model.
        popped_n    = 0;
        delivered_n = 0;
        for (int n = 0; n < 3000; n++) begin
            while (src.size() < 6) src.push_back(DSIZE'($urandom));
            stall         = ($urandom_range(0, 3) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 7) == 0);
            cycle();
        end

        // Drain everything that is left, bounded.
        stall         = 1'b0;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        guard         = 0;
        while ((src.size() != 0 || acc.size() != 0 || presenting) && guard < 64) begin
            cycle();
            guard++;
        end
        bus.flush = 1'b0;
        check("drain_bound", guard < 64, 1'b1);
        check("src_drained", src.size(), 0);
        check("no_loss", delivered_n, popped_n);
        check("end_valid", bus.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter DSIZE, default 8, width of one FIFO data word (byte).
REQ-002 Parameter LANES, default 4, bytes packed per output word; legal values 2, 4, 8.
REQ-003 Parameter CSIZE, default 3, width of the lane count, equal to clog2(LANES)+1.
REQ-004 rclk  input  1  single clock; all state updates on the rising edge.
REQ-005 rrst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of rclk.
REQ-006 rdata  input  DSIZE  FIFO head data, valid whenever rempty is 0 (first-word-fall-through).
REQ-007 rempty  input  1  FIFO empty flag.
REQ-008 rinc  output  1  FIFO pop strobe; one byte is consumed per rclk edge with rinc=1.
REQ-009 flush  input  1  request to emit a partially filled word.
REQ-010 out_data  output  LANES*DSIZE  packed word; lane 0 is bits [DSIZE-1:0].
REQ-011 out_bytes  output  CSIZE  number of valid lanes in out_data, 1..LANES, while out_valid is 1.
REQ-012 out_valid  output  1  packed word available.
REQ-013 out_ready  input  1  downstream accepts; transfer occurs on an edge with out_valid=1 and out_ready=1.

Function
REQ-014 The block SHALL implement two states: FILL (collecting bytes) and OUT (presenting a word).
REQ-015 The block SHALL hold a lane counter cnt of width CSIZE, range 0..LANES-1, in FILL.
REQ-016 rinc SHALL be combinational: !rempty && rrst_n && ((FILL && !(flush && cnt!=0)) || (OUT && out_ready)).
REQ-017 On each pop, rdata SHALL be written into lane cnt, and cnt SHALL increment.
REQ-018 A pop into lane 0 SHALL clear lanes 1..LANES-1 in the same edge.
REQ-019 A pop into lane LANES-1 in FILL SHALL move the block to OUT with out_valid=1 and out_bytes=LANES on the next cycle.
REQ-020 Under full-rate supply, the first word SHALL appear LANES cycles after the first pop.
REQ-021 In FILL with flush=1 and cnt!=0, the block SHALL skip the pop that cycle.
REQ-022 In that case, the block SHALL enter OUT with out_bytes=cnt, and unpopulated lanes SHALL read 0.
REQ-023 flush SHALL be ignored in FILL when cnt=0, and SHALL be ignored in OUT.
REQ-024 In OUT with out_ready=0, out_data, out_bytes and out_valid SHALL hold stable, and rinc SHALL be 0.
REQ-025 In OUT with out_ready=1 and a pop, the byte SHALL go to lane 0 of the next word, and the state SHALL become FILL with cnt=1.
REQ-026 This pop-during-handshake SHALL give sustained throughput of one word per LANES cycles.
REQ-027 In OUT with out_ready=1 and no pop (rempty=1), the state SHALL become FILL with cnt=0 and out_valid=0.
REQ-028 The next word SHALL start with lane 0, and out_data SHALL hold the last value until that lane 0 write.
REQ-029 rempty=1 in FILL SHALL stall collection without loss, and cnt SHALL hold.
REQ-030 cnt SHALL wrap from LANES-1 to 0 on the transition to OUT.
REQ-031 out_bytes SHALL never be 0 while out_valid=1.
REQ-032 out_valid SHALL be driven directly from a register.

Reset
REQ-033 With rrst_n=0 at a rising edge of rclk: state=FILL, cnt=0, out_valid=0, out_bytes=0, out_data=0.
REQ-034 rinc SHALL be 0 while rrst_n=0.
REQ-035 Reset mid-word or during OUT SHALL discard the partial or pending word without popping.
REQ-036 The first pop after reset SHALL occur no earlier than the first edge with rrst_n=1.

Verification
REQ-037 Scenario: bytes 11,22,33,44 with rempty=0 and out_ready=1 -> out_data=44332211, out_bytes=4, out_valid=1 for one cycle.
REQ-038 Scenario: 8 back-to-back bytes 01..08 with out_ready=1 -> words 04030201 then 08070605, 4 cycles apart, with rinc never deasserted.
REQ-039 Scenario: 3 bytes AA,BB,CC, then rempty=1, then flush pulse -> out_data=00CCBBAA, out_bytes=3; flush with cnt=0 -> no output.
REQ-040 Scenario: full word presented with out_ready=0 for 5 cycles and rempty=0 -> rinc=0 and out_data stable; on out_ready=1 -> one pop into lane 0.
REQ-041 Scenario: rrst_n=0 after 2 bytes popped -> all outputs 0; next 4 bytes form a clean word with no stale lanes.
REQ-042 Scenario: random rempty/out_ready/flush against a byte-queue scoreboard -> byte order preserved, no loss or duplication, out_bytes matches populated lanes.
